// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO CMD53 data-phase sequencer.
// State and status encodings, R5 IO_CURRENT_STATE values, byte-mode length helper.
package sdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CMD,
    ISSUE,
    WAIT_BUSY,
    WAIT_END,
    GAP
  } seq_state_t;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_CRC_ERR = 2'd1,
    STATUS_ABORTED = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } seq_status_t;

  localparam logic [1:0] IO_DIS = 2'd0;
  localparam logic [1:0] IO_CMD = 2'd1;
  localparam logic [1:0] IO_TRN = 2'd2;

  localparam int BYTE_WRAP_LEN = 512;

  // A CMD53 byte count of zero encodes the full 512-byte transfer.
  function automatic logic [11:0] effective_length(input logic [8:0] count);
    return (count == 9'd0) ? 12'(BYTE_WRAP_LEN) : {3'b000, count};
  endfunction

endpackage

// File: rtl/sdio_gap_timer.sv
// Loadable down-counter with a zero flag; counts down to zero and holds there.
// Shared by the command gap, start timeout and inter-block gap of the sequencer.
module sdio_gap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sdio_cmd53_sequencer.sv
// CMD53 (IO_RW_EXTENDED) data-phase sequencer for function 1: waits for the R5
// response to clear, strobes the DAT engine once per block and reports the outcome.
module sdio_cmd53_sequencer
  import sdio_pkg::*;
#(
  parameter int CMD_GAP        = 6,
  parameter int BLOCK_GAP      = 2,
  parameter int START_TIMEOUT  = 15,
  parameter int MAX_BLOCK_SIZE = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        start_write,
  input  logic        start_block_mode,
  input  logic [8:0]  start_count,
  input  logic [11:0] block_size,
  input  logic        card_selected,
  input  logic        send_command_in_progress,
  input  logic        data_busy,
  input  logic        data_error,
  input  logic        abort,
  output logic        write_data4_strobe,
  output logic        read_data4_strobe,
  output logic [11:0] data4_count,
  output logic        busy,
  output logic        start_reject,
  output logic        done,
  output logic [1:0]  status,
  output logic [8:0]  blocks_done,
  output logic [1:0]  io_state
);

  localparam int TIMER_W = 8;

  seq_state_t  state_reg, state_next;
  seq_status_t status_reg, finish_status;

  logic               write_dir_reg;
  logic               block_mode_reg;
  logic [8:0]         count_reg;
  logic [11:0]        data4_count_reg;
  logic [8:0]         blocks_done_reg;
  logic [8:0]         blocks_inc_value;
  logic               write_strobe_reg, read_strobe_reg;
  logic               busy_reg, done_reg, start_reject_reg;
  logic [1:0]         io_state_reg;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  logic [11:0]        request_length;
  logic               request_legal;
  logic               accept, reject, finish, block_inc;

  sdio_gap_timer #(
    .WIDTH (TIMER_W)
  ) u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  assign request_length   = start_block_mode ? block_size : effective_length(start_count);
  assign request_legal    = (block_size != 12'd0) &&
                            (block_size <= 12'(MAX_BLOCK_SIZE)) &&
                            (start_block_mode || (effective_length(start_count) <= block_size));
  assign blocks_inc_value = blocks_done_reg + 9'd1;

  always_comb begin
    state_next    = state_reg;
    timer_load    = 1'b0;
    timer_value   = '0;
    accept        = 1'b0;
    reject        = 1'b0;
    finish        = 1'b0;
    finish_status = STATUS_OK;
    block_inc     = 1'b0;

    if (start && ((state_reg != IDLE) || !request_legal)) begin
      reject = 1'b1;
    end

    // abort and data_error are meaningless while idle, so a start always wins there
    if (state_reg == IDLE) begin
      if (start && request_legal) begin
        accept      = 1'b1;
        state_next  = WAIT_CMD;
        timer_load  = 1'b1;
        timer_value = TIMER_W'(CMD_GAP);
      end
    end else if (abort) begin
      finish        = 1'b1;
      finish_status = STATUS_ABORTED;
      state_next    = IDLE;
    end else if (data_error) begin
      finish        = 1'b1;
      finish_status = STATUS_CRC_ERR;
      state_next    = IDLE;
    end else begin
      case (state_reg)
        WAIT_CMD: begin
          if (timer_zero && !send_command_in_progress) begin
            state_next  = ISSUE;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(START_TIMEOUT);
          end
        end
        ISSUE: state_next = WAIT_BUSY;
        WAIT_BUSY: begin
          if (data_busy) begin
            state_next = WAIT_END;
          end else if (timer_zero) begin
            finish        = 1'b1;
            finish_status = STATUS_TIMEOUT;
            state_next    = IDLE;
          end
        end
        WAIT_END: begin
          if (!data_busy) begin
            block_inc = 1'b1;
            // count 0 in block mode never matches, so the transfer runs until stopped
            if (!block_mode_reg || ((count_reg != 9'd0) && (blocks_inc_value == count_reg))) begin
              finish     = 1'b1;
              state_next = IDLE;
            end else begin
              state_next  = GAP;
              timer_load  = 1'b1;
              timer_value = TIMER_W'(BLOCK_GAP);
            end
          end
        end
        GAP: begin
          if (timer_zero) begin
            state_next  = ISSUE;
            timer_load  = 1'b1;
            timer_value = TIMER_W'(START_TIMEOUT);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      status_reg       <= STATUS_OK;
      write_dir_reg    <= 1'b0;
      block_mode_reg   <= 1'b0;
      count_reg        <= '0;
      data4_count_reg  <= '0;
      blocks_done_reg  <= '0;
      write_strobe_reg <= 1'b0;
      read_strobe_reg  <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      start_reject_reg <= 1'b0;
      io_state_reg     <= IO_DIS;
    end else begin
      state_reg        <= state_next;
      status_reg       <= finish ? finish_status : STATUS_OK;
      done_reg         <= finish;
      start_reject_reg <= reject;
      busy_reg         <= (state_next != IDLE);
      // A host write means the card receives, hence the read strobe
      read_strobe_reg  <= (state_next == ISSUE) && write_dir_reg;
      write_strobe_reg <= (state_next == ISSUE) && !write_dir_reg;

      if (state_next != IDLE) begin
        io_state_reg <= IO_TRN;
      end else if (card_selected) begin
        io_state_reg <= IO_CMD;
      end else begin
        io_state_reg <= IO_DIS;
      end

      if (accept) begin
        write_dir_reg   <= start_write;
        block_mode_reg  <= start_block_mode;
        count_reg       <= start_count;
        data4_count_reg <= request_length;
        blocks_done_reg <= '0;
      end else if (block_inc) begin
        blocks_done_reg <= blocks_inc_value;
      end
    end
  end

  assign write_data4_strobe = write_strobe_reg;
  assign read_data4_strobe  = read_strobe_reg;
  assign data4_count        = data4_count_reg;
  assign busy               = busy_reg;
  assign start_reject       = start_reject_reg;
  assign done               = done_reg;
  assign status             = status_reg;
  assign blocks_done        = blocks_done_reg;
  assign io_state           = io_state_reg;

endmodule

// File: tb/tb_sdio_cmd53_sequencer.sv
// Directed self-checking bench for sdio_cmd53_sequencer; inputs change 1 time unit
// after a rising edge, outputs are sampled at the same point.
module tb_sdio_cmd53_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        start_write;
  logic        start_block_mode;
  logic [8:0]  start_count;
  logic [11:0] block_size;
  logic        card_selected;
  logic        send_command_in_progress;
  logic        data_busy;
  logic        data_error;
  logic        abort;
  logic        write_data4_strobe;
  logic        read_data4_strobe;
  logic [11:0] data4_count;
  logic        busy;
  logic        start_reject;
  logic        done;
  logic [1:0]  status;
  logic [8:0]  blocks_done;
  logic [1:0]  io_state;

  int cyc;
  int checks;
  int passes;

  sdio_cmd53_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .start                    (start),
    .start_write              (start_write),
    .start_block_mode         (start_block_mode),
    .start_count              (start_count),
    .block_size               (block_size),
    .card_selected            (card_selected),
    .send_command_in_progress (send_command_in_progress),
    .data_busy                (data_busy),
    .data_error               (data_error),
    .abort                    (abort),
    .write_data4_strobe       (write_data4_strobe),
    .read_data4_strobe        (read_data4_strobe),
    .data4_count              (data4_count),
    .busy                     (busy),
    .start_reject             (start_reject),
    .done                     (done),
    .status                   (status),
    .blocks_done              (blocks_done),
    .io_state                 (io_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic issue_start(input logic wr, input logic bm, input logic [8:0] cnt, input logic [11:0] bs);
    start_write      = wr;
    start_block_mode = bm;
    start_count      = cnt;
    block_size       = bs;
    start            = 1'b1;
    tick();
    start            = 1'b0;
  endtask

  // Advance until either strobe is seen; e stays -1 if the budget runs out.
  task automatic wait_strobe(input int limit, output int e, output logic rd, output logic wr);
    e  = -1;
    rd = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (read_data4_strobe === 1'b1 || write_data4_strobe === 1'b1) begin
        e  = cyc;
        rd = read_data4_strobe;
        wr = write_data4_strobe;
        break;
      end
    end
  endtask

  // Engine model: busy for busy_len cycles right after the strobe, then drop.
  task automatic serve_block(input int busy_len, output int fall_edge, output logic strobe_after);
    data_busy = 1'b1;
    tick();
    strobe_after = read_data4_strobe | write_data4_strobe;
    for (int i = 1; i < busy_len; i++) tick();
    data_busy = 1'b0;
    fall_edge = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    card_selected = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else passes++;
    checks++; if ({read_data4_strobe, write_data4_strobe} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {read_data4_strobe, write_data4_strobe}); else passes++;
    checks++; if (start_reject !== 1'b0) $display("FAIL rst_reject: got %0b want 0", start_reject); else passes++;
    checks++; if (data4_count !== 12'd0) $display("FAIL rst_count: got %0d want 0", data4_count); else passes++;
    checks++; if (blocks_done !== 9'd0) $display("FAIL rst_blocks: got %0d want 0", blocks_done); else passes++;
    checks++; if (status !== 2'd0) $display("FAIL rst_status: got %0d want 0", status); else passes++;
    checks++; if (io_state !== 2'd0) $display("FAIL rst_io_state: got %0d want 0", io_state); else passes++;
    reset = 1'b0;
    tick();
    checks++; if (io_state !== 2'd1) $display("FAIL rst_io_cmd: got %0d want 1", io_state); else passes++;
    $display("reset: outputs cleared, io_state=%0d after release", io_state);
  endtask

  task automatic test_block_write();
    int s0, e, fall, exp_e;
    logic rd, wr, after;
    issue_start(1'b1, 1'b1, 9'd3, 12'd64);
    s0 = cyc;
    checks++; if (busy !== 1'b1) $display("FAIL blk_busy_rise: got %0b want 1", busy); else passes++;
    checks++; if (io_state !== 2'd2) $display("FAIL blk_io_trn: got %0d want 2", io_state); else passes++;
    exp_e = s0 + 7;
    for (int b = 0; b < 3; b++) begin
      wait_strobe(40, e, rd, wr);
      checks++; if (e != exp_e) $display("FAIL blk_strobe_edge[%0d]: got %0d want %0d", b, e, exp_e); else passes++;
      checks++; if ({rd, wr} !== 2'b10) $display("FAIL blk_strobe_dir[%0d]: got rd/wr %b want 10", b, {rd, wr}); else passes++;
      checks++; if (data4_count !== 12'd64) $display("FAIL blk_len[%0d]: got %0d want 64", b, data4_count); else passes++;
      checks++; if (blocks_done !== 9'(b)) $display("FAIL blk_progress[%0d]: got %0d want %0d", b, blocks_done, b); else passes++;
      serve_block(3, fall, after);
      checks++; if (after !== 1'b0) $display("FAIL blk_strobe_width[%0d]: got %0b want 0", b, after); else passes++;
      exp_e = fall + 4;
    end
    tick();
    checks++; if (done !== 1'b1) $display("FAIL blk_done: got %0b want 1", done); else passes++;
    checks++; if (status !== 2'd0) $display("FAIL blk_status: got %0d want 0", status); else passes++;
    checks++; if (blocks_done !== 9'd3) $display("FAIL blk_total: got %0d want 3", blocks_done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL blk_busy_fall: got %0b want 0", busy); else passes++;
    checks++; if (io_state !== 2'd1) $display("FAIL blk_io_after: got %0d want 1", io_state); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL blk_done_width: got %0b want 0", done); else passes++;
    $display("block write: 3 x 64 bytes, blocks_done=%0d", blocks_done);
  endtask

  task automatic test_byte_read();
    int s0, e, fall;
    logic rd, wr, after;
    issue_start(1'b0, 1'b0, 9'd0, 12'd512);
    s0 = cyc;
    wait_strobe(30, e, rd, wr);
    checks++; if (e != s0 + 7) $display("FAIL byte_strobe_edge: got %0d want %0d", e, s0 + 7); else passes++;
    checks++; if ({rd, wr} !== 2'b01) $display("FAIL byte_strobe_dir: got rd/wr %b want 01", {rd, wr}); else passes++;
    checks++; if (data4_count !== 12'd512) $display("FAIL byte_len: got %0d want 512", data4_count); else passes++;
    serve_block(3, fall, after);
    tick();
    checks++; if (done !== 1'b1 || status !== 2'd0) $display("FAIL byte_done: got done=%0b status=%0d want 1/0", done, status); else passes++;
    checks++; if (blocks_done !== 9'd1) $display("FAIL byte_blocks: got %0d want 1", blocks_done); else passes++;
    $display("byte read: count 0 -> %0d bytes", data4_count);
  endtask

  task automatic test_illegal();
    logic bad;
    issue_start(1'b1, 1'b0, 9'd100, 12'd64);
    checks++; if (start_reject !== 1'b1) $display("FAIL ill_reject: got %0b want 1", start_reject); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ill_busy: got %0b want 0", busy); else passes++;
    tick();
    checks++; if (start_reject !== 1'b0) $display("FAIL ill_reject_width: got %0b want 0", start_reject); else passes++;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy || read_data4_strobe || write_data4_strobe || done) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) $display("FAIL ill_quiet: got activity=%0b want 0", bad); else passes++;
    issue_start(1'b1, 1'b1, 9'd2, 12'd0);
    checks++; if (start_reject !== 1'b1) $display("FAIL ill_bs_zero: got %0b want 1", start_reject); else passes++;
    tick();
    issue_start(1'b1, 1'b1, 9'd2, 12'd513);
    checks++; if (start_reject !== 1'b1) $display("FAIL ill_bs_513: got %0b want 1", start_reject); else passes++;
    tick();
    // count equal to block_size is the largest legal byte-mode request
    issue_start(1'b1, 1'b0, 9'd64, 12'd64);
    checks++; if (start_reject !== 1'b0 || busy !== 1'b1) $display("FAIL ill_edge_legal: got reject=%0b busy=%0b want 0/1", start_reject, busy); else passes++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || status !== 2'd2) $display("FAIL ill_edge_abort: got done=%0b status=%0d want 1/2", done, status); else passes++;
    tick();
    $display("illegal requests: rejected, boundary byte count accepted");
  endtask

  task automatic test_cmd_busy();
    int s0, base, e, fall;
    logic rd, wr, after, early;
    send_command_in_progress = 1'b1;
    issue_start(1'b1, 1'b1, 9'd1, 12'd32);
    s0 = cyc;
    base = s0 - 1;
    early = 1'b0;
    while (cyc < base + 20) begin
      tick();
      if (read_data4_strobe || write_data4_strobe) early = 1'b1;
    end
    send_command_in_progress = 1'b0;
    wait_strobe(20, e, rd, wr);
    checks++; if (early !== 1'b0) $display("FAIL cmd_early_strobe: got %0b want 0", early); else passes++;
    checks++; if (e != base + 21) $display("FAIL cmd_strobe_edge: got %0d want %0d", e, base + 21); else passes++;
    serve_block(3, fall, after);
    tick();
    checks++; if (done !== 1'b1 || status !== 2'd0) $display("FAIL cmd_done: got done=%0b status=%0d want 1/0", done, status); else passes++;
    $display("cmd busy: strobe at relative edge %0d", e - base);
  endtask

  task automatic test_abort(input logic with_err);
    int e, fall, exp_e, s0;
    logic rd, wr, after, bad;
    issue_start(1'b0, 1'b1, 9'd0, 12'd16);
    s0 = cyc;
    exp_e = s0 + 7;
    for (int b = 0; b < 5; b++) begin
      wait_strobe(40, e, rd, wr);
      checks++; if (e != exp_e || {rd, wr} !== 2'b01) $display("FAIL abt_strobe[%0d]: got edge %0d rd/wr %b want %0d 01", b, e, {rd, wr}, exp_e); else passes++;
      serve_block(3, fall, after);
      exp_e = fall + 4;
    end
    tick();
    checks++; if (blocks_done !== 9'd5) $display("FAIL abt_progress: got %0d want 5", blocks_done); else passes++;
    abort = 1'b1;
    data_error = with_err;
    tick();
    abort = 1'b0;
    data_error = 1'b0;
    checks++; if (done !== 1'b1 || status !== 2'd2) $display("FAIL abt_done(err=%0b): got done=%0b status=%0d want 1/2", with_err, done, status); else passes++;
    checks++; if (blocks_done !== 9'd5 || busy !== 1'b0) $display("FAIL abt_final: got blocks=%0d busy=%0b want 5/0", blocks_done, busy); else passes++;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (read_data4_strobe || write_data4_strobe || done || busy) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL abt_quiet: got activity=%0b want 0", bad); else passes++;
    $display("unbounded abort (data_error=%0b): status=2 blocks_done=%0d", with_err, blocks_done);
  endtask

  task automatic test_crc_error();
    int e;
    logic rd, wr;
    issue_start(1'b1, 1'b1, 9'd2, 12'd64);
    wait_strobe(30, e, rd, wr);
    data_busy = 1'b1;
    tick();
    tick();
    data_error = 1'b1;
    tick();
    data_error = 1'b0;
    data_busy = 1'b0;
    checks++; if (done !== 1'b1 || status !== 2'd1) $display("FAIL crc_done: got done=%0b status=%0d want 1/1", done, status); else passes++;
    checks++; if (blocks_done !== 9'd0) $display("FAIL crc_blocks: got %0d want 0", blocks_done); else passes++;
    tick();
    $display("crc error: status=1 blocks_done=%0d", blocks_done);
  endtask

  task automatic test_timeout();
    int s, de;
    logic rd, wr, st_busy;
    logic [1:0] st;
    issue_start(1'b0, 1'b1, 9'd2, 12'd64);
    wait_strobe(30, s, rd, wr);
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (start_reject !== 1'b1 || busy !== 1'b1) $display("FAIL to_reject: got reject=%0b busy=%0b want 1/1", start_reject, busy); else passes++;
    de = -1;
    st = 2'd0;
    st_busy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) begin
        de = cyc;
        st = status;
        st_busy = busy;
        break;
      end
    end
    checks++; if (de != s + 16) $display("FAIL to_done_edge: got %0d want %0d", de, s + 16); else passes++;
    checks++; if (st !== 2'd3 || st_busy !== 1'b0) $display("FAIL to_status: got status=%0d busy=%0b want 3/0", st, st_busy); else passes++;
    $display("timeout: done at strobe+%0d", de - s);
  endtask

  task automatic test_start_with_abort();
    start_write = 1'b1;
    start_block_mode = 1'b1;
    start_count = 9'd4;
    block_size = 12'd128;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || start_reject !== 1'b0) $display("FAIL sa_accept: got busy=%0b done=%0b reject=%0b want 1/0/0", busy, done, start_reject); else passes++;
    checks++; if (data4_count !== 12'd128) $display("FAIL sa_len: got %0d want 128", data4_count); else passes++;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || status !== 2'd2 || blocks_done !== 9'd0) $display("FAIL sa_abort: got done=%0b status=%0d blocks=%0d want 1/2/0", done, status, blocks_done); else passes++;
    tick();
    $display("start+abort in idle: accepted, later abort status=2");
  endtask

  task automatic test_reset_mid();
    int s0;
    logic bad;
    issue_start(1'b1, 1'b1, 9'd1, 12'd64);
    s0 = cyc;
    while (cyc < s0 + 6) tick();
    reset = 1'b1;
    tick();
    checks++; if ({read_data4_strobe, write_data4_strobe, done, busy} !== 4'b0000) $display("FAIL rm_outputs: got strobes/done/busy %b want 0000", {read_data4_strobe, write_data4_strobe, done, busy}); else passes++;
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (read_data4_strobe || write_data4_strobe || done || busy) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL rm_quiet: got activity=%0b want 0", bad); else passes++;
    $display("reset mid-transfer: no strobe, no done");
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    passes = 0;
    reset = 1'b1;
    start = 1'b0;
    start_write = 1'b0;
    start_block_mode = 1'b0;
    start_count = 9'd0;
    block_size = 12'd0;
    card_selected = 1'b0;
    send_command_in_progress = 1'b0;
    data_busy = 1'b0;
    data_error = 1'b0;
    abort = 1'b0;
    test_reset();
    test_block_write();
    tick();
    test_byte_read();
    tick();
    test_illegal();
    test_cmd_busy();
    tick();
    test_abort(1'b0);
    test_abort(1'b1);
    test_crc_error();
    test_timeout();
    tick();
    test_start_with_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
